fxp_ratio_div: RTL and testbench
================================

Name: fxp_ratio_div

Overview:
Computes the signed Q(W-F).F ratio num/den by multiplying num with a reciprocal of den. The reciprocal comes from the existing iterative reciprocal unit through a start/done side port. Sits directly downstream of that reciprocal unit in the watchdog datapath. Adds valid/ready handshakes, saturation, a watchdog timeout on the reciprocal handshake, and an error code.

Parameters:
W, 32, data width of num/den/result and of rc_x/rc_inv
F, 16, fractional bits (Q16.16 default)
TIMEOUT, 64, max cycles spent in WAIT before aborting
TO_W, 7, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
num  in  W  signed numerator, QF
den  in  W  signed denominator, QF
rc_start  out  1  one-cycle start pulse to reciprocal unit
rc_x  out  W  denominator to reciprocal unit, signed
rc_done  in  1  reciprocal unit result valid (single-cycle pulse)
rc_inv  in  W  unsigned QF reciprocal
rc_invalid  in  1  reciprocal unit rejected input (x<=0), qualified by rc_done
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  W  signed QF num/den
err_code  out  2  0 = ok, 1 = invalid denominator, 2 = timeout, 3 = saturated

Behaviour:
- Reset (async): state IDLE. in_ready=1, rc_start=0, rc_x=0, out_valid=0, result=0, err_code=0, timeout counter=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch num into num_r and den into rc_x, then go to REQ.
  - REQ: rc_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - On rc_done=1, latch rc_inv and rc_invalid, then go to MUL.
    - Else if counter reaches TIMEOUT-1: result=0, err_code=2, go to OUT.
  - MUL: compute the 2W-bit signed product num_r * {1'b0,rc_inv}, arithmetically shifted right by F (floor rounding).
    - If rc_invalid: result=0, err_code=1.
    - Else if shifted product > 2^(W-1)-1: result=0x7FFF..F, err_code=3.
    - Else if shifted product < -2^(W-1): result=0x800..0, err_code=3.
    - Else: result=low W bits, err_code=0.
    - Go to OUT.
  - OUT: out_valid=1; result and err_code stay stable. On out_ready, go to IDLE (out_valid low next cycle).
- rc_x is held unchanged from acceptance until the MUL state is entered. The reciprocal unit resamples x at its final cycle, so rc_x must be stable through the rc_done cycle.
- Latency: accept at edge t0 → rc_start high in cycle t0+1 → rc_done sampled at edge td → out_valid from td+2. Total is 2 + reciprocal latency + 1 cycles.
- in_ready=0 in every state except IDLE. Only one operation is in flight; there is no queue.
- An rc_done arriving outside WAIT (late pulse after a timeout, or a stray pulse) is ignored and latches nothing.
- rc_done in the same cycle the counter hits TIMEOUT-1: rc_done wins, and the operation is not a timeout.
- out_ready held high with no pending result has no effect. out_ready low stalls indefinitely in OUT, with no timeout.
- Reset mid-operation returns to IDLE immediately; rc_start is deasserted asynchronously. The reciprocal unit shares rst_n and restarts too.
- den<=0 is not checked locally; it is reported via rc_invalid as err_code=1.

Decomposition:
- Shared package (watchdog package) holds:
  - state enum IDLE/REQ/WAIT/MUL/OUT (logic [2:0]);
  - err_code constants ERR_OK, ERR_INVALID, ERR_TIMEOUT, ERR_SAT;
  - Q-format constants W_DEF=32, F_DEF=16.
- One natural sub-module: fxp_sat_mul. It is combinational: signed W × unsigned W, >>> F, saturate to signed W, with a sat flag out. It is reusable by other QF stages.
- The FSM, timeout counter and handshakes stay in fxp_ratio_div.

Test Plan:
- num=0x00030000, den=0x00020000; model returns rc_inv=0x00008000 with rc_done 10 cycles after rc_start → result=0x00018000, err_code=0, out_valid exactly 2 cycles after rc_done, one rc_start pulse.
- num=0xFFFD0000 (-3.0), rc_inv=0x00008000 → result=0xFFFE8000 (-1.5), err_code=0; rc_x=0x00020000 is stable from acceptance through the rc_done cycle.
- den=0x00000000; model asserts rc_done with rc_invalid=1, rc_inv=0 → result=0, err_code=1.
- num=0x7FFF0000, rc_inv=0x00040000 → result=0x7FFFFFFF, err_code=3. num=0x80000000, rc_inv=0x00040000 → result=0x80000000, err_code=3.
- Model never asserts rc_done → out_valid after 64 WAIT cycles, result=0, err_code=2. A late rc_done pulse 5 cycles later has no effect, and the next operation completes normally.
- out_ready held low 5 cycles → result and err_code stable, in_ready=0 throughout. Separately, rst_n pulsed low in WAIT → rc_start=0 and out_valid=0 immediately, and in_ready=1 after release.

Source files
------------

// File: rtl/fxp_ratio_div_pkg.sv
// Shared definitions for the watchdog datapath QF ratio stage.
// Holds the controller state encoding, the error code values reported on
// err_code and the default Q-format (Q16.16) parameters.
package fxp_ratio_div_pkg;

  localparam int W_DEF = 32;
  localparam int F_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    MUL  = 3'd3,
    OUT  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_INVALID = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SAT     = 2'd3;

endpackage

// File: rtl/fxp_sat_mul.sv
// Combinational QF multiplier: signed W-bit a times unsigned W-bit b,
// arithmetic shift right by F (floor rounding), saturated to signed W bits.
// Ports:
//   a   : signed QF operand
//   b   : unsigned QF operand
//   y   : saturated signed QF product
//   sat : high when y was clamped to the positive or negative limit
module fxp_sat_mul
  import fxp_ratio_div_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int F = F_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         sat
);

  logic signed [2*W-1:0] a_ext_s;
  logic signed [2*W-1:0] b_ext_s;
  logic signed [2*W-1:0] prod_s;
  logic signed [2*W-1:0] shift_s;
  logic        [W:0]     top_s;

  // b is unsigned, so it is zero-extended; the 2W-bit product cannot overflow.
  assign a_ext_s = $signed({{W{a[W-1]}}, a});
  assign b_ext_s = $signed({{W{1'b0}}, b});
  assign prod_s  = a_ext_s * b_ext_s;
  assign shift_s = prod_s >>> F;

  // The shifted value fits in W signed bits exactly when bits [2W-1:W-1]
  // are all copies of the sign bit.
  assign top_s = shift_s[2*W-1:W-1];

  // Saturate toward the sign of the full-width shifted product.
  always_comb begin
    y   = shift_s[W-1:0];
    sat = 1'b0;
    if ((top_s == {(W+1){1'b0}}) || (top_s == {(W+1){1'b1}})) begin
      y   = shift_s[W-1:0];
      sat = 1'b0;
    end else if (shift_s[2*W-1]) begin
      y   = {1'b1, {(W-1){1'b0}}};
      sat = 1'b1;
    end else begin
      y   = {1'b0, {(W-1){1'b1}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fxp_ratio_div.sv
// Signed QF ratio num/den computed as num * (1/den). The reciprocal is
// obtained from the iterative reciprocal unit over a start/done side port,
// guarded by a watchdog timeout, then multiplied and saturated.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake (num, den in QF)
//   rc_start/rc_x         : start pulse and denominator to reciprocal unit
//   rc_done/rc_inv/rc_invalid : reciprocal result, qualified by rc_done
//   out_valid/out_ready   : result handshake
//   result/err_code       : signed QF ratio and status (ok/invalid/timeout/sat)
module fxp_ratio_div
  import fxp_ratio_div_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int F       = F_DEF,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         rc_start,
  output logic [W-1:0] rc_x,
  input  logic         rc_done,
  input  logic [W-1:0] rc_inv,
  input  logic         rc_invalid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [1:0]   err_code
);

  state_t          state_r;
  logic [W-1:0]    num_r;
  logic [W-1:0]    inv_r;
  logic            invalid_r;
  logic [TO_W-1:0] cnt_r;
  logic [W-1:0]    mul_y_s;
  logic            mul_sat_s;

  fxp_sat_mul #(
    .W (W),
    .F (F)
  ) u_mul (
    .a   (num_r),
    .b   (inv_r),
    .y   (mul_y_s),
    .sat (mul_sat_s)
  );

  // Controller: one operation in flight, all handshake outputs registered.
  // rc_x is only written on acceptance, so it stays stable through rc_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      rc_start  <= 1'b0;
      rc_x      <= {W{1'b0}};
      out_valid <= 1'b0;
      result    <= {W{1'b0}};
      err_code  <= ERR_OK;
      num_r     <= {W{1'b0}};
      inv_r     <= {W{1'b0}};
      invalid_r <= 1'b0;
      cnt_r     <= {TO_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            num_r    <= num;
            rc_x     <= den;
            in_ready <= 1'b0;
            rc_start <= 1'b1;
            state_r  <= REQ;
          end
        end
        REQ: begin
          rc_start <= 1'b0;
          cnt_r    <= {TO_W{1'b0}};
          state_r  <= WAIT;
        end
        WAIT: begin
          cnt_r <= cnt_r + TO_W'(1);
          // rc_done takes priority over an expiring counter in the same cycle.
          if (rc_done) begin
            inv_r     <= rc_inv;
            invalid_r <= rc_invalid;
            state_r   <= MUL;
          end else if (cnt_r == TO_W'(TIMEOUT - 1)) begin
            result    <= {W{1'b0}};
            err_code  <= ERR_TIMEOUT;
            out_valid <= 1'b1;
            state_r   <= OUT;
          end
        end
        MUL: begin
          if (invalid_r) begin
            result   <= {W{1'b0}};
            err_code <= ERR_INVALID;
          end else if (mul_sat_s) begin
            result   <= mul_y_s;
            err_code <= ERR_SAT;
          end else begin
            result   <= mul_y_s;
            err_code <= ERR_OK;
          end
          out_valid <= 1'b1;
          state_r   <= OUT;
        end
        OUT: begin
          // No timeout here: a stalled consumer holds the result indefinitely.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          rc_start  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_ratio_div.sv
// Self-checking bench for fxp_ratio_div: directed cases from the test plan,
// reset behaviour, then randomized operations checked against an integer
// arithmetic reference model.
module tb_fxp_ratio_div;
  import fxp_ratio_div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num;
  logic [31:0] den;
  logic        rc_start;
  logic [31:0] rc_x;
  logic        rc_done;
  logic [31:0] rc_inv;
  logic        rc_invalid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  fxp_ratio_div #(.W(32), .F(16), .TIMEOUT(64), .TO_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .num        (num),
    .den        (den),
    .rc_start   (rc_start),
    .rc_x       (rc_x),
    .rc_done    (rc_done),
    .rc_inv     (rc_inv),
    .rc_invalid (rc_invalid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product, floor division by 2^16, clamp to int32.
  function automatic void ref_model(input logic [31:0] n, input logic [31:0] inv,
                                    input bit bad, output logic [31:0] r,
                                    output logic [1:0] e);
    longint a, b, p, q, scale;
    scale = longint'(1) << 16;
    a = longint'($signed(n));
    b = longint'({32'd0, inv});
    p = a * b;
    q = p / scale;
    if (((p % scale) != 0) && (p < 0)) q = q - 1;
    if (bad) begin
      r = 32'h0; e = ERR_INVALID;
    end else if (q > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF; e = ERR_SAT;
    end else if (q < -64'sd2147483648) begin
      r = 32'h8000_0000; e = ERR_SAT;
    end else begin
      r = 32'(q); e = ERR_OK;
    end
  endfunction

  // One full operation. lat = cycles from the rc_start cycle to the rc_done
  // cycle; respond=0 means the reciprocal unit never answers.
  task automatic do_op(input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] inv, input bit bad, input int lat,
                       input bit respond, input logic [31:0] exp_r,
                       input logic [1:0] exp_e, input int stall, input bit late,
                       input string tag);
    bit ok;
    chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1; num = n; den = d;
    step();
    in_valid = 1'b0; num = $urandom; den = $urandom;
    chk({tag, "_rc_start"}, rc_start, 1'b1);
    chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
    chk({tag, "_rc_x"}, rc_x, d);
    ok = 1'b1;
    if (respond) begin
      for (int i = 0; i < lat; i++) begin
        step();
        if (rc_start !== 1'b0 || rc_x !== d || out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
      end
      rc_done = 1'b1; rc_inv = inv; rc_invalid = bad;
      step();
      rc_done = 1'b0; rc_inv = $urandom; rc_invalid = 1'b0;
      chk({tag, "_wait_phase"}, ok, 1'b1);
      chk({tag, "_mul_no_valid"}, out_valid, 1'b0);
      step();
    end else begin
      for (int i = 0; i < 64; i++) begin
        step();
        if (rc_start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
      end
      chk({tag, "_wait_phase"}, ok, 1'b1);
      step();
    end
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_err_code"}, err_code, exp_e);
    ok = 1'b1;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (late && s == 4) begin
        rc_done = 1'b1; rc_inv = 32'h0000_8000; rc_invalid = 1'b0;
      end
      step();
      rc_done = 1'b0;
      if (result !== exp_r || err_code !== exp_e || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    if (stall > 0) chk({tag, "_stall_stable"}, ok, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] rn, rd, ri, er;
    logic [1:0]  ee;
    bit          rb;

    rst_n = 1'b0; in_valid = 1'b0; num = 32'h0; den = 32'h0;
    rc_done = 1'b0; rc_inv = 32'h0; rc_invalid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rc_start", rc_start, 1'b0);
    chk("rst_rc_x", rc_x, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_err_code", err_code, 2'd0);

    // out_ready high with nothing pending does nothing.
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    chk("idle_ready_no_valid", out_valid, 1'b0);
    chk("idle_ready_in_ready", in_ready, 1'b1);

    do_op(32'h0003_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 10, 1'b1, 32'h0001_8000, ERR_OK, 0, 1'b0, "basic");
    do_op(32'hFFFD_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 7, 1'b1, 32'hFFFE_8000, ERR_OK, 0, 1'b0, "neg");
    do_op(32'h0003_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 4, 1'b1, 32'h0000_0000, ERR_INVALID, 0, 1'b0, "inv_den");
    do_op(32'h7FFF_0000, 32'h0000_4000, 32'h0004_0000, 1'b0, 3, 1'b1, 32'h7FFF_FFFF, ERR_SAT, 0, 1'b0, "sat_pos");
    do_op(32'h8000_0000, 32'h0000_4000, 32'h0004_0000, 1'b0, 3, 1'b1, 32'h8000_0000, ERR_SAT, 0, 1'b0, "sat_neg");
    do_op(32'h0005_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 0, 1'b0, 32'h0000_0000, ERR_TIMEOUT, 5, 1'b1, "timeout");
    do_op(32'h0001_0000, 32'h0004_0000, 32'h0000_4000, 1'b0, 2, 1'b1, 32'h0000_4000, ERR_OK, 0, 1'b0, "after_to");
    do_op(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 5, 1'b1, 32'h0002_0000, ERR_OK, 5, 1'b0, "stall");
    do_op(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 64, 1'b1, 32'h0001_0000, ERR_OK, 0, 1'b0, "done_at_limit");

    // Stray rc_done in IDLE latches nothing and starts nothing.
    rc_done = 1'b1; rc_inv = 32'hFFFF_FFFF;
    step();
    rc_done = 1'b0;
    step();
    chk("stray_out_valid", out_valid, 1'b0);
    chk("stray_in_ready", in_ready, 1'b1);

    // Reset while waiting on the reciprocal unit.
    in_valid = 1'b1; num = 32'h0001_0000; den = 32'h0001_0000;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0; #1;
    chk("rst_wait_rc_start", rc_start, 1'b0);
    chk("rst_wait_out_valid", out_valid, 1'b0);
    chk("rst_wait_in_ready_async", in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_wait_in_ready", in_ready, 1'b1);
    chk("rst_wait_rc_x", rc_x, 32'h0);

    // Reset during the start pulse drops rc_start without a clock edge.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst_req_pre", rc_start, 1'b1);
    rst_n = 1'b0; #1;
    chk("rst_req_rc_start", rc_start, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Reset while a result is held drops out_valid without a clock edge.
    in_valid = 1'b1; num = 32'h0001_0000; den = 32'h0001_0000;
    step();
    in_valid = 1'b0;
    step();
    rc_done = 1'b1; rc_inv = 32'h0002_0000;
    step();
    rc_done = 1'b0;
    step();
    chk("rst_out_pre", out_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk("rst_out_out_valid", out_valid, 1'b0);
    chk("rst_out_result", result, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      rn = $urandom >> $urandom_range(0, 16);
      if ($urandom_range(0, 1) == 1) rn = -rn;
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) ri = $urandom_range(0, 32'h0004_0000);
      else ri = $urandom;
      rb = ($urandom_range(0, 7) == 0);
      ref_model(rn, ri, rb, er, ee);
      do_op(rn, rd, ri, rb, $urandom_range(1, 20), 1'b1, er, ee,
            $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
